// File: rtl/i_cache_dm.sv
// i_cache_dm: direct-mapped instruction cache between the fetch PC and a
// word-wide backing memory. Hits return the instruction combinationally in
// the lookup cycle. A miss stalls fetch and refills the whole line one word
// at a time over a valid/ready memory port, with at most one request
// outstanding.
// Optional macro ICACHE_PERF_EN adds saturating hit_cnt/miss_cnt outputs.
module i_cache_dm #(
  parameter int AddrWidth = 32,
  parameter int LineWords = 4,
  parameter int NumLines  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [AddrWidth-1:0] PCF,
  input  logic                 pc_valid,
  input  logic                 flush,
  output logic [31:0]          instr,
  output logic                 instr_valid,
  output logic                 stall,
  output logic                 mem_req,
  output logic [AddrWidth-1:0] mem_addr,
  input  logic                 mem_gnt,
  input  logic                 mem_rvalid,
  input  logic [31:0]          mem_rdata
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]          hit_cnt,
  output logic [31:0]          miss_cnt
`endif
);

  localparam int WordW = $clog2(LineWords);
  localparam int OffW  = WordW + 2;
  localparam int IdxW  = $clog2(NumLines);
  localparam int TagW  = AddrWidth - OffW - IdxW;

  typedef enum logic {S_IDLE = 1'b0, S_REFILL = 1'b1} state_t;

  state_t             r_state;
  logic [NumLines-1:0] r_valid;
  logic [TagW-1:0]    r_tag  [NumLines];
  logic [31:0]        r_data [NumLines*LineWords];
  logic [TagW-1:0]    r_line_tag;
  logic [IdxW-1:0]    r_line_idx;
  logic [WordW-1:0]   r_req_cnt;
  logic [WordW-1:0]   r_rsp_cnt;
  logic               r_outst;     // a granted request awaits its response
  logic               r_req_done;  // all LineWords requests accepted
  logic               r_flushed;   // flush seen during this refill
  logic               r_hold;      // first cycle after reset release

  logic [TagW-1:0]    w_tag;
  logic [IdxW-1:0]    w_idx;
  logic [WordW-1:0]   w_word;
  logic               w_active;
  logic               w_idle;
  logic               w_hit;
  logic               w_miss;
  logic               w_rsp;
  logic               w_last_rsp;
  logic               w_unused;

  assign w_tag  = PCF[AddrWidth-1 -: TagW];
  assign w_idx  = PCF[OffW+IdxW-1:OffW];
  assign w_word = PCF[OffW-1:2];
  // Byte offset within a word is irrelevant for a word-wide fetch.
  assign w_unused = ^PCF[1:0];

  // Outputs are forced quiet while in reset and for one cycle afterwards.
  assign w_active = rst_n & ~r_hold;
  assign w_idle   = w_active & (r_state == S_IDLE);
  assign w_hit    = w_idle & pc_valid & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
  assign w_miss   = w_idle & pc_valid & ~w_hit & ~flush;

  assign instr_valid = w_hit & ~flush;
  assign instr       = instr_valid ? r_data[{w_idx, w_word}] : 32'h0;
  assign stall       = w_miss | (w_active & (r_state == S_REFILL));

  assign mem_req  = w_active & (r_state == S_REFILL) & ~r_outst & ~r_req_done;
  assign mem_addr = {r_line_tag, r_line_idx, r_req_cnt, 2'b00};

  // Responses are only accepted while one is actually owed to this refill.
  assign w_rsp      = rst_n & (r_state == S_REFILL) & r_outst & mem_rvalid;
  assign w_last_rsp = w_rsp & (r_rsp_cnt == WordW'(LineWords - 1));

  // Control state: refill FSM, beat counters and line valid bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_valid    <= '0;
      r_req_cnt  <= '0;
      r_rsp_cnt  <= '0;
      r_outst    <= 1'b0;
      r_req_done <= 1'b0;
      r_flushed  <= 1'b0;
      r_hold     <= 1'b1;
      r_line_tag <= '0;
      r_line_idx <= '0;
    end else begin
      r_hold <= 1'b0;
      if (flush) r_valid <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_miss) begin
            r_state    <= S_REFILL;
            r_line_tag <= w_tag;
            r_line_idx <= w_idx;
            r_req_cnt  <= '0;
            r_rsp_cnt  <= '0;
            r_outst    <= 1'b0;
            r_req_done <= 1'b0;
            r_flushed  <= 1'b0;
          end
        end
        S_REFILL: begin
          if (flush) r_flushed <= 1'b1;
          if (mem_req && mem_gnt) begin
            r_req_cnt <= r_req_cnt + 1'b1;
            r_outst   <= 1'b1;
            if (r_req_cnt == WordW'(LineWords - 1)) r_req_done <= 1'b1;
          end
          if (w_rsp) begin
            r_outst   <= 1'b0;
            r_rsp_cnt <= r_rsp_cnt + 1'b1;
          end
          // A flush anywhere in the refill leaves the line invalid.
          if (w_last_rsp) begin
            r_state <= S_IDLE;
            if (!flush && !r_flushed) r_valid[r_line_idx] <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Data and tag storage: written by refill responses, never reset.
  always_ff @(posedge clk) begin
    if (w_rsp) r_data[{r_line_idx, r_rsp_cnt}] <= mem_rdata;
    if (w_last_rsp) r_tag[r_line_idx] <= r_line_tag;
  end

`ifdef ICACHE_PERF_EN
  // Saturating performance counters; flush leaves them untouched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (instr_valid && (hit_cnt != 32'hFFFF_FFFF)) hit_cnt <= hit_cnt + 32'd1;
      if (w_miss && (miss_cnt != 32'hFFFF_FFFF)) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule
